// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit with HI/LO and a fixed-latency busy countdown.
// Optional multiply-accumulate ops (madd/maddu/msub/msubu) are enabled by MD_MADD_EN.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        req,
  output logic [4:0]  busyCnt,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  localparam logic [4:0] MULT_CNT = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_CNT  = 5'(DIV_CYCLES);

  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] tmp_hi_q, tmp_hi_d, tmp_lo_q, tmp_lo_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        commit_q, commit_d;

  logic        accept_s;
  logic [63:0] mul_s_s, mul_u_s;
  logic [31:0] a_mag_s, b_mag_s, b_div_s, b_udiv_s;
  logic [31:0] q_mag_s, r_mag_s;
  logic [31:0] div_q_s, div_r_s, divu_q_s, divu_r_s;
`ifdef MD_MADD_EN
  logic [63:0] acc_s;
`endif

  assign accept_s = start & ~req & (cnt_q == 5'd0);

  // Products: low 64 bits of sign/zero-extended operands give the exact 32x32 result.
  always_comb begin
    mul_s_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    mul_u_s = {32'd0, A} * {32'd0, B};
  end

  // Signed division is done on magnitudes so 0x80000000 / -1 wraps to 0x80000000 cleanly.
  always_comb begin
    a_mag_s  = A[31] ? (32'd0 - A) : A;
    b_mag_s  = B[31] ? (32'd0 - B) : B;
    b_div_s  = (b_mag_s == 32'd0) ? 32'd1 : b_mag_s;
    b_udiv_s = (B == 32'd0) ? 32'd1 : B;
    q_mag_s  = a_mag_s / b_div_s;
    r_mag_s  = a_mag_s % b_div_s;
    div_q_s  = (A[31] ^ B[31]) ? (32'd0 - q_mag_s) : q_mag_s;
    div_r_s  = A[31] ? (32'd0 - r_mag_s) : r_mag_s;
    divu_q_s = A / b_udiv_s;
    divu_r_s = A % b_udiv_s;
  end

`ifdef MD_MADD_EN
  // Accumulator operand is the architectural {HI,LO} at acceptance.
  always_comb begin
    acc_s = {hi_q, lo_q};
  end
`endif

  // Next-state: countdown with commit on 1->0, otherwise accept a new op when idle.
  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    tmp_hi_d = tmp_hi_q;
    tmp_lo_d = tmp_lo_q;
    cnt_d    = cnt_q;
    commit_d = commit_q;
    if (cnt_q != 5'd0) begin
      cnt_d = cnt_q - 5'd1;
      if ((cnt_q == 5'd1) && commit_q) begin
        hi_d = tmp_hi_q;
        lo_d = tmp_lo_q;
      end else begin
        hi_d = hi_q;
      end
    end else if (accept_s) begin
      case (op)
        OP_MULT: begin
          {tmp_hi_d, tmp_lo_d} = mul_s_s;
          cnt_d    = MULT_CNT;
          commit_d = 1'b1;
        end
        OP_MULTU: begin
          {tmp_hi_d, tmp_lo_d} = mul_u_s;
          cnt_d    = MULT_CNT;
          commit_d = 1'b1;
        end
        OP_DIV: begin
          tmp_hi_d = div_r_s;
          tmp_lo_d = div_q_s;
          cnt_d    = DIV_CNT;
          commit_d = (B != 32'd0);
        end
        OP_DIVU: begin
          tmp_hi_d = divu_r_s;
          tmp_lo_d = divu_q_s;
          cnt_d    = DIV_CNT;
          commit_d = (B != 32'd0);
        end
        OP_MTHI: hi_d = A;
        OP_MTLO: lo_d = A;
`ifdef MD_MADD_EN
        OP_MADD: begin
          {tmp_hi_d, tmp_lo_d} = acc_s + mul_s_s;
          cnt_d    = MULT_CNT;
          commit_d = 1'b1;
        end
        OP_MADDU: begin
          {tmp_hi_d, tmp_lo_d} = acc_s + mul_u_s;
          cnt_d    = MULT_CNT;
          commit_d = 1'b1;
        end
        OP_MSUB: begin
          {tmp_hi_d, tmp_lo_d} = acc_s - mul_s_s;
          cnt_d    = MULT_CNT;
          commit_d = 1'b1;
        end
        OP_MSUBU: begin
          {tmp_hi_d, tmp_lo_d} = acc_s - mul_u_s;
          cnt_d    = MULT_CNT;
          commit_d = 1'b1;
        end
`endif
        default: cnt_d = cnt_q;
      endcase
    end else begin
      cnt_d = cnt_q;
    end
    busy_d = (cnt_d != 5'd0);
  end

  // State registers with synchronous reset; reset mid-operation discards the pending result.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      tmp_hi_q <= 32'd0;
      tmp_lo_q <= 32'd0;
      cnt_q    <= 5'd0;
      busy_q   <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      tmp_hi_q <= tmp_hi_d;
      tmp_lo_q <= tmp_lo_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      commit_q <= commit_d;
    end
  end

  assign busyCnt = cnt_q;
  assign busy    = busy_q;
  assign HI      = hi_q;
  assign LO      = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit with default parameters (5 / 10 cycles).
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        req;
  logic [4:0]  busyCnt;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int errors;
  int checks;

  mult_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B), .req(req),
    .busyCnt(busyCnt), .busy(busy), .HI(HI), .LO(LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an op for one edge, then drop start.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input logic r);
    start = 1'b1; op = o; A = a; B = b; req = r;
    tick();
    start = 1'b0; op = 4'd0; req = 1'b0;
  endtask

  // Run down the countdown; n is the number of further edges needed to reach idle.
  task automatic finish_op(input string tag, input int n);
    int cyc;
    cyc = 0;
    while (busyCnt != 5'd0 && cyc < 40) begin
      tick();
      cyc++;
    end
    chk({tag, "_cycles"}, 32'(cyc), 32'(n));
  endtask

  initial begin
    errors = 0; checks = 0;
    reset = 1'b1; start = 1'b0; op = 4'd0; A = 32'd0; B = 32'd0; req = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_cnt", 32'(busyCnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // mult -2 * 3 with cycle-by-cycle countdown and stable HI/LO
    issue(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    chk("mult_cnt5", 32'(busyCnt), 32'd5);
    chk("mult_busy", 32'(busy), 32'd1);
    for (int k = 4; k >= 1; k--) begin
      tick();
      chk("mult_cnt", 32'(busyCnt), 32'(k));
      chk("mult_hold_hi", HI, 32'd0);
      chk("mult_hold_lo", LO, 32'd0);
    end
    tick();
    chk("mult_cnt0", 32'(busyCnt), 32'd0);
    chk("mult_idle", 32'(busy), 32'd0);
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFFA);

    // multu max * max
    issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    finish_op("multu", 5);
    chk("multu_hi", HI, 32'hFFFF_FFFE);
    chk("multu_lo", LO, 32'h0000_0001);

    // div -7 / 2
    issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("div_cnt10", 32'(busyCnt), 32'd10);
    finish_op("div", 10);
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);

    // signed overflow
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    finish_op("divovf", 10);
    chk("divovf_lo", LO, 32'h8000_0000);
    chk("divovf_hi", HI, 32'h0000_0000);

    // divu 100 / 7
    issue(4'd4, 32'd100, 32'd7, 1'b0);
    finish_op("divu", 10);
    chk("divu_lo", LO, 32'd14);
    chk("divu_hi", HI, 32'd2);

    // divu by zero leaves HI/LO alone
    issue(4'd5, 32'h11, 32'd0, 1'b0);
    issue(4'd6, 32'h22, 32'd0, 1'b0);
    issue(4'd4, 32'd7, 32'd0, 1'b0);
    chk("divz_cnt10", 32'(busyCnt), 32'd10);
    finish_op("divz", 10);
    chk("divz_hi", HI, 32'h11);
    chk("divz_lo", LO, 32'h22);

    // mthi then mtlo on consecutive cycles
    start = 1'b1; op = 4'd5; A = 32'h1234;
    tick();
    chk("mthi_hi", HI, 32'h1234);
    chk("mthi_cnt", 32'(busyCnt), 32'd0);
    op = 4'd6; A = 32'h5678;
    tick();
    start = 1'b0; op = 4'd0;
    chk("mtlo_lo", LO, 32'h5678);
    chk("mtlo_hi", HI, 32'h1234);
    chk("mtlo_cnt", 32'(busyCnt), 32'd0);

    // req cancels mult and mthi
    issue(4'd1, 32'd2, 32'd3, 1'b1);
    chk("req_cnt", 32'(busyCnt), 32'd0);
    issue(4'd5, 32'hDEAD, 32'd0, 1'b1);
    tick();
    chk("req_hi", HI, 32'h1234);
    chk("req_lo", LO, 32'h5678);

    // op 0, undefined op, and op 7 (accumulate only when enabled)
    issue(4'd0, 32'hAAAA, 32'd1, 1'b0);
    issue(4'd15, 32'hBBBB, 32'd1, 1'b0);
    chk("undef_cnt", 32'(busyCnt), 32'd0);
    chk("undef_hi", HI, 32'h1234);
    chk("undef_lo", LO, 32'h5678);
`ifdef MD_MADD_EN
    issue(4'd7, 32'hFFFF_FFFF, 32'd2, 1'b0);
    finish_op("madd", 5);
    chk("madd_hi", HI, 32'h1234);
    chk("madd_lo", LO, 32'h5676);
`else
    issue(4'd7, 32'd2, 32'd3, 1'b0);
    chk("madd_off_cnt", 32'(busyCnt), 32'd0);
    chk("madd_off_lo", LO, 32'h5678);
`endif

    // start while busy is ignored; req while busy does not disturb the op
    issue(4'd1, 32'd2, 32'd3, 1'b0);
    issue(4'd4, 32'd100, 32'd7, 1'b0);
    chk("ign_cnt4", 32'(busyCnt), 32'd4);
    req = 1'b1;
    tick();
    req = 1'b0;
    chk("ign_cnt3", 32'(busyCnt), 32'd3);
    finish_op("ign", 3);
    chk("ign_hi", HI, 32'd0);
    chk("ign_lo", LO, 32'd6);

    // reset mid-div
    issue(4'd3, 32'd50, 32'd3, 1'b0);
    for (int k = 0; k < 6; k++) tick();
    chk("rstmid_cnt4", 32'(busyCnt), 32'd4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstmid_cnt", 32'(busyCnt), 32'd0);
    chk("rstmid_hi", HI, 32'd0);
    chk("rstmid_lo", LO, 32'd0);
    tick();
    chk("rstmid_cnt_after", 32'(busyCnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- E-stage multiply/divide unit with HI/LO registers for the P7 MIPS pipeline.
- Accepts a one-cycle `start` from E with an MD op code and operands, then runs a fixed-latency countdown.
- Produces the `busyCnt`/`start` pair that the hazard unit samples to stall MD instructions in D.
- Supplies HI/LO to the E-stage mfhi/mflo path.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd family); legal range 1..31.
- DIV_CYCLES, 10, busy cycles for div/divu; legal range 1..31.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  E-stage MD instruction valid this cycle; also routed unchanged to the hazard unit
- op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu; codes 7-10 are valid only under MD_MADD_EN
- A  input  32  rs operand, already forwarded
- B  input  32  rt operand, already forwarded
- req  input  1  exception/interrupt taken this cycle; cancels the E-stage instruction
- busyCnt  output  5  remaining busy cycles, 0 when idle
- busy  output  1  (busyCnt != 0)
- HI  output  32  HI register
- LO  output  32  LO register

Behaviour:
- Reset: HI=0, LO=0, busyCnt=0, internal result registers=0. Reset mid-operation aborts the operation; HI/LO are not updated.
- Accepted op: start=1 && req=0 && busyCnt==0. If start=1 with busyCnt!=0, the op is ignored; the hazard unit guarantees this never occurs. If req=1, the op is ignored, including mthi/mtlo.
- Idle → Busy, on accepted op 1-4 (or 7-10):
  - Compute the result combinationally from A/B into tmpHI/tmpLO.
  - busyCnt <= MULT_CYCLES or DIV_CYCLES.
- Busy countdown: each edge busyCnt <= busyCnt-1. On the edge where busyCnt goes 1→0, HI<=tmpHI and LO<=tmpLO.
- Latency: new HI/LO are visible in the first cycle busyCnt==0. Example: start at edge 0 with MULT_CYCLES=5 → HI/LO valid after edge 5.
- mult: signed 32x32→64; HI=product[63:32], LO=product[31:0]. multu: same, unsigned.
- div: LO=$signed(A)/$signed(B), HI=$signed(A)%$signed(B); quotient truncates toward zero, remainder takes the sign of the dividend. divu: same, unsigned.
- Signed overflow: 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide by zero (B==0): still busy for DIV_CYCLES, but HI/LO are left unchanged at completion.
- mthi: HI<=A on the next edge. mtlo: LO<=A on the next edge. No busy cycles; busyCnt stays 0.
- op=0, or an undefined op with start=1: no state change.
- req asserted while busy: the in-flight op is unaffected and completes normally; its instruction has already committed past E.
- HI/LO are stable throughout Busy.

Optional Feature:
- Macro: MD_MADD_EN.
- Defined:
  - op 7 madd: {HI,LO} + signed A*B.
  - op 8 maddu: {HI,LO} + unsigned A*B.
  - op 9 msub: {HI,LO} - signed A*B.
  - op 10 msubu: {HI,LO} - unsigned A*B.
  - All four: 64-bit wrap-around arithmetic, {HI,LO} sampled at acceptance, MULT_CYCLES latency, same commit rule as mult.
- Not defined: ops 7-10 are treated as op 0 (no state change, no busy); the accumulate datapath is not synthesized.

Test Plan:
- mult A=0xFFFFFFFE (-2), B=3, start 1 cycle:
  - busyCnt reads 5,4,3,2,1 on successive cycles.
  - At busyCnt=0: HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - HI/LO hold their old values during countdown.
- multu A=0xFFFFFFFF, B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001 after 5 cycles.
- div A=-7 (0xFFFFFFF9), B=2:
  - busyCnt starts at 10.
  - Result LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- divu A=7, B=0 with prior HI=0x11, LO=0x22: busy for 10 cycles, then HI=0x11, LO=0x22 unchanged.
- mthi A=0x1234, then mtlo A=0x5678 on consecutive cycles:
  - HI=0x1234 after first edge, LO=0x5678 after second.
  - busyCnt stays 0 throughout.
- Cancel and reset:
  - start mult with req=1 → busyCnt stays 0, HI/LO unchanged.
  - start div, assert reset at busyCnt=4 → next cycle busyCnt=0, HI=LO=0.
  - start with busyCnt!=0 → ignored, countdown continues.
